// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one load/store at a time onto a big-endian byte-addressed 32-bit memory port,
// with sign/zero-extended sub-word loads and read-modify-write sub-word stores.
module mem_access_unit #(
  parameter int ADDR_W = 6,
  parameter int MEM_BYTES = 51
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [31:0]       mem_out32
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  localparam logic [ADDR_W:0] last_byte = (ADDR_W+1)'(MEM_BYTES - 1);
  state_t state;
  logic wr_q, op_write, op_signed, req_err;
  logic [1:0] op_size, op_off;
  logic [4:0] sh;
  logic [31:0] op_wdata, mask, raw, ext, merged;
  logic [ADDR_W:0] top;
  assign req_ready = state == IDLE && !reset;
  assign mem_memwrite = wr_q && !reset;
  assign top = {1'b0, req_addr[ADDR_W-1:2], 2'b11};
  assign req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00) || top > last_byte;
  // shift that brings the addressed big-endian lane down to bit 0
  assign sh = op_size == 2'b00 ? {~op_off, 3'b000} : op_size == 2'b01 ? {~op_off[1], 4'b0000} : 5'd0;
  assign mask = op_size == 2'b00 ? 32'h0000_00ff : op_size == 2'b01 ? 32'h0000_ffff : 32'hffff_ffff;
  assign raw = (mem_out32 >> sh) & mask;
  assign ext = op_size == 2'b00 ? {{24{op_signed & raw[7]}}, raw[7:0]} :
               op_size == 2'b01 ? {{16{op_signed & raw[15]}}, raw[15:0]} : raw;
  assign merged = (mem_out32 & ~(mask << sh)) | ((op_wdata & mask) << sh);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      wr_q <= 1'b0;
      mem_memread <= 1'b0;
      mem_address <= '0;
      mem_writeData <= '0;
      op_write <= 1'b0;
      op_signed <= 1'b0;
      op_size <= '0;
      op_off <= '0;
      op_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_write <= req_write;
          op_signed <= req_signed;
          op_size <= req_size;
          op_off <= req_addr[1:0];
          op_wdata <= req_wdata;
          if (req_err) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= '0;
          end else if (req_write && req_size == 2'b10) begin
            state <= WR;
            wr_q <= 1'b1;
            mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_writeData <= req_wdata;
          end else begin
            state <= RD;
            mem_memread <= 1'b1;
            mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
          end
        end
        RD: begin
          mem_memread <= 1'b0;
          if (op_write) begin
            state <= WR;
            wr_q <= 1'b1;
            mem_writeData <= merged;
          end else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b0;
            rsp_rdata <= ext;
          end
        end
        WR: begin
          wr_q <= 1'b0;
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte-array memory and a byte-level reference model.
module tb_mem_access_unit;
  localparam int ADDR_W = 6;
  localparam int MEM_BYTES = 51;
  logic clk, reset, req_valid, req_ready, req_write, req_signed;
  logic [1:0] req_size;
  logic [ADDR_W-1:0] req_addr, mem_address;
  logic [31:0] req_wdata, rsp_rdata, mem_writeData, mem_out32;
  logic rsp_valid, rsp_err, mem_memwrite, mem_memread;
  logic [7:0] mem [0:63];
  logic [7:0] ref_mem [0:63];
  typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  bit strobe_seen = 0;
  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_out32(mem_out32)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb mem_out32 = {mem[mem_address], mem[mem_address + 6'd1], mem[mem_address + 6'd2], mem[mem_address + 6'd3]};
  always @(posedge clk)
    if (mem_memwrite) for (int i = 0; i < 4; i++) mem[mem_address + 6'(i)] = mem_writeData[31-8*i -: 8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference: bytes read/written one at a time in big-endian order
  function automatic void model(input bit w, input logic [1:0] sz, input bit sg, input logic [5:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic [31:0] v;
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    er = sz == 3 || (int'(a) % n) != 0 || (int'(a) / 4) * 4 + 3 > MEM_BYTES - 1;
    rd = 0;
    lat = 1;
    if (er) return;
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*(n-1-i) +: 8];
      lat = n == 4 ? 2 : 3;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8*n));
      rd = v;
      lat = 2;
    end
  endfunction
  task automatic issue(input bit w, input logic [1:0] sz, input bit sg, input logic [5:0] a,
                       input logic [31:0] wd, input bit track, output int acc);
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat, budget;
    budget = 0;
    @(negedge clk);
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    acc = cyc;
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready 0 expected 1");
      req_valid = 0;
      return;
    end
    if (track) begin
      model(w, sz, sg, a, wd, rd, er, lat);
      e.rdata = rd; e.err = er; e.cyc = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
  endtask
  task automatic drop();
    @(negedge clk);
    req_valid = 0;
  endtask
  task automatic check_reset_vals();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_memwrite", 32'(mem_memwrite), 0);
    chk("rst_memread", 32'(mem_memread), 0);
    chk("rst_address", 32'(mem_address), 0);
    chk("rst_writedata", mem_writeData, 0);
    chk("rst_req_ready", 32'(req_ready), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (reset) strobe_seen = 0;
    else begin
      if (mem_memread || mem_memwrite) strobe_seen = 1;
      chk("strobe_overlap", 32'(mem_memread && mem_memwrite), 0);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid 1 with no request outstanding");
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          if (e.err) chk("err_strobes", 32'(strobe_seen), 0);
        end
        strobe_seen = 0;
      end
    end
  end
  initial begin
    int a1, a2, budget;
    logic [1:0] sz;
    logic [5:0] ad;
    reset = 1; req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[0] = 8'h00; mem[1] = 8'h43; mem[2] = 8'h08; mem[3] = 8'h22;
    for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 0;
    issue(0, 2'b10, 0, 6'd0, 0, 1, a1);
    issue(1, 2'b00, 0, 6'd2, 32'h1234_56f0, 1, a1);
    issue(0, 2'b10, 0, 6'd0, 0, 1, a1);
    issue(0, 2'b00, 1, 6'd2, 0, 1, a1);
    drop();
    issue(0, 2'b01, 1, 6'd2, 0, 1, a1);
    issue(0, 2'b01, 0, 6'd2, 0, 1, a1);
    issue(0, 2'b01, 1, 6'd0, 0, 1, a1);
    issue(0, 2'b10, 0, 6'd2, 0, 1, a1);
    issue(0, 2'b01, 0, 6'd1, 0, 1, a1);
    issue(0, 2'b11, 0, 6'd4, 0, 1, a1);
    issue(0, 2'b00, 0, 6'd48, 0, 1, a1);
    issue(1, 2'b10, 0, 6'd48, 32'hdead_beef, 1, a1);
    // reset lands in the write cycle of a read-modify-write; the write must be dropped
    issue(1, 2'b00, 0, 6'd1, 32'h0000_005a, 0, a1);
    @(negedge clk);
    @(negedge clk);
    chk("rmw_wr_strobe", 32'(mem_memwrite), 1);
    reset = 1;
    req_valid = 0;
    @(negedge clk);
    check_reset_vals();
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 1);
    issue(0, 2'b10, 0, 6'd0, 0, 1, a1);
    issue(1, 2'b10, 0, 6'd8, $urandom, 1, a1);
    issue(1, 2'b10, 0, 6'd12, $urandom, 1, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 3);
    drop();
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) ad = sz == 2'b00 ? ad : sz == 2'b01 ? {ad[5:1], 1'b0} : {ad[5:2], 2'b00};
      issue(1'($urandom), sz, 1'($urandom), ad, $urandom, 1, a1);
      if ($urandom_range(0, 1) == 1) drop();
    end
    drop();
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_queue", 32'(q.size()), 0);
    for (int i = 0; i < MEM_BYTES; i++) chk("mem_byte", 32'(mem[i]), 32'(ref_mem[i]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
